// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronises rxd, finds the start edge, samples each bit
// at mid-bit and strobes out the received byte or a framing error.
module uart_rx_core #(
    parameter int unsigned CLKS_9600  = 5208,
    parameter int unsigned CLKS_19200 = 2604
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sel,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rxd_m;
    logic             rxd_s;
    logic             rxd_p;
    logic             sel_f;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] bit_max;
    logic [CNT_W-1:0] half_max;
    logic [CNT_W-1:0] limit;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             fall;
    logic             counting;
    logic             sample;
    logic             start_c;
    logic             shift_c;
    logic             valid_c;
    logic             ferr_c;

    // Two-flop synchroniser plus previous-sample register for edge detection
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_p <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_p <= rxd_s;
        end
    end

    assign fall     = rxd_p & ~rxd_s;
    assign bit_max  = sel_f ? CNT_W'(CLKS_19200) : CNT_W'(CLKS_9600);
    assign half_max = bit_max >> 1;
    assign limit    = (state == START) ? half_max : bit_max;
    assign counting = (state == START) || (state == DATA) || (state == STOP);
    assign sample   = counting && (cnt == limit);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (fall)   state_nxt = START;
            START:     if (sample) state_nxt = rxd_s ? IDLE : DATA;
            DATA:      if (sample && (bit_idx == 3'd7)) state_nxt = STOP;
            STOP:      if (sample) state_nxt = rxd_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rxd_s)  state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_c = 1'b0;
        shift_c = 1'b0;
        valid_c = 1'b0;
        ferr_c  = 1'b0;
        case (state)
            IDLE: start_c = fall;
            DATA: shift_c = sample;
            STOP: begin
                valid_c = sample & rxd_s;
                ferr_c  = sample & ~rxd_s;
            end
            default: ;
        endcase
    end

    // Frame baud latch, bit-period counter, bit index and LSB-first shifter
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sel_f   <= 1'b0;
            cnt     <= CNT_W'(1);
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (start_c) sel_f <= sel;
            if (counting && !sample) cnt <= cnt + CNT_W'(1);
            else                     cnt <= CNT_W'(1);
            if ((state == START) && sample) bit_idx <= 3'd0;
            else if (shift_c)               bit_idx <= bit_idx + 3'd1;
            if (shift_c) shift <= {rxd_s, shift[7:1]};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= valid_c;
            frame_err <= ferr_c;
            busy      <= (state_nxt != IDLE);
            if (valid_c) rx_data <= shift;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with a byte scoreboard; bit periods are
// scaled down so the full plan stays short.
module tb_uart_rx_core;

    localparam int unsigned B9  = 104;
    localparam int unsigned B19 = 52;

    logic       clk   = 1'b0;
    logic       n_rst = 1'b0;
    logic       sel   = 1'b0;
    logic       rxd   = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         vcnt     = 0;
    int         fcnt     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_core #(
        .CLKS_9600 (B9),
        .CLKS_19200(B19)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .sel      (sel),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1)  vcnt++;
        if (frame_err === 1'b1) fcnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 frame starting at a negedge; good frames go to the scoreboard
    task automatic send_byte(input logic [7:0] d, input logic stop, input int unsigned bt);
        if (stop) exp_q.push_back(d);
        rxd = 1'b0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (bt) @(negedge clk);
        end
        rxd = stop;
        repeat (bt) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic expect_valid(input string tag, input int budget, output int waited);
        logic [7:0] e;
        waited = 0;
        while (rx_valid !== 1'b1 && frame_err !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, 32'(rx_valid), 32'd1);
        if (rx_valid === 1'b1) begin
            check({tag, "_ferr"}, 32'(frame_err), 32'd0);
            check({tag, "_busy"}, 32'(busy), 32'd0);
            check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check({tag, "_data"}, 32'(rx_data), 32'(e));
                last_good = e;
            end
            @(negedge clk);
            check({tag, "_pulse"}, 32'(rx_valid), 32'd0);
        end
    endtask

    task automatic expect_ferr(input string tag, input int budget);
        int waited;
        waited = 0;
        while (frame_err !== 1'b1 && rx_valid !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ferr"}, 32'(frame_err), 32'd1);
        check({tag, "_novalid"}, 32'(rx_valid), 32'd0);
        check({tag, "_data_kept"}, 32'(rx_data), 32'(last_good));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        int w;
        int v0;
        int f0;
        logic [7:0] d6;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 0xA5 at 9600, with latency window
        sel = 1'b0;
        v0 = vcnt; f0 = fcnt;
        fork
            send_byte(8'hA5, 1'b1, B9);
            expect_valid("t1", 12 * B9, w);
        join
        check("t1_latency", 32'((w >= 989) && (w <= 993)), 32'd1);
        repeat (20) @(negedge clk);
        check("t1_count", 32'(vcnt - v0), 32'd1);
        check("t1_noferr", 32'(fcnt - f0), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // 2: 0x3C then 0xFF back-to-back at 19200
        sel = 1'b1;
        v0 = vcnt;
        fork
            begin
                send_byte(8'h3C, 1'b1, B19);
                send_byte(8'hFF, 1'b1, B19);
            end
            begin
                expect_valid("t2a", 12 * B19, w);
                expect_valid("t2b", 12 * B19, w);
            end
        join
        repeat (20) @(negedge clk);
        check("t2_count", 32'(vcnt - v0), 32'd2);

        // 3: short low glitch is rejected at the half-bit sample
        sel = 1'b0;
        v0 = vcnt; f0 = fcnt;
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_busy_hi", 32'(busy), 32'd1);
        repeat (15) @(negedge clk);
        rxd = 1'b1;
        repeat (B9) @(negedge clk);
        check("t3_busy_lo", 32'(busy), 32'd0);
        check("t3_nostrobe", 32'(vcnt - v0 + fcnt - f0), 32'd0);
        check("t3_data", 32'(rx_data), 32'(last_good));

        // 4: framing error with line held low, then recovery
        v0 = vcnt; f0 = fcnt;
        fork
            begin
                send_byte(8'h55, 1'b0, B9);
                rxd = 1'b0;
                repeat (3 * B9) @(negedge clk);
                check("t4_hold_busy", 32'(busy), 32'd1);
                check("t4_hold_novalid", 32'(vcnt - v0), 32'd0);
                rxd = 1'b1;
            end
            expect_ferr("t4", 12 * B9);
        join
        repeat (10) @(negedge clk);
        check("t4_fcount", 32'(fcnt - f0), 32'd1);
        check("t4_recover", 32'(busy), 32'd0);
        fork
            send_byte(8'h12, 1'b1, B9);
            expect_valid("t4n", 12 * B9, w);
        join
        repeat (10) @(negedge clk);

        // 5: sel toggled during bit 3 must not affect this frame
        sel = 1'b0;
        fork
            send_byte(8'h81, 1'b1, B9);
            begin
                repeat (4 * B9 + B9 / 2) @(negedge clk);
                sel = 1'b1;
            end
            expect_valid("t5", 12 * B9, w);
        join
        sel = 1'b0;
        repeat (10) @(negedge clk);

        // 6: asynchronous reset during bit 5 aborts the frame
        v0 = vcnt; f0 = fcnt;
        d6 = 8'hA6;
        rxd = 1'b0;
        repeat (B9) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rxd = d6[i];
            repeat (B9) @(negedge clk);
        end
        rxd = d6[5];
        repeat (B9 / 2) @(negedge clk);
        check("t6_busy_pre", 32'(busy), 32'd1);
        n_rst = 1'b0;
        #1;
        check("t6_rst_data", 32'(rx_data), 32'h00);
        check("t6_rst_busy", 32'(busy), 32'd0);
        rxd = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (2 * B9) @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_nostrobe", 32'(vcnt - v0 + fcnt - f0), 32'd0);
        check("t6_data", 32'(rx_data), 32'h00);
        fork
            send_byte(8'h7E, 1'b1, B9);
            expect_valid("t6n", 12 * B9, w);
        join
        repeat (10) @(negedge clk);

        check("end_sb_empty", 32'(exp_q.size()), 32'd0);
        check("end_valid_total", 32'(vcnt), 32'd6);
        check("end_ferr_total", 32'(fcnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
